// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arb_pkg
//  Description : Shared types and constants for the register-file write
//                arbiter. It holds the arbiter state type, the default
//                register-file geometry, and a helper that returns the width
//                of an index field.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_arb_pkg;

  // Arbiter session state.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int RF_DATA_W  = 16;
  localparam int RF_ADDR_W  = 4;
  localparam int RF_DEPTH   = 16;
  localparam int RF_NUM_REQ = 4;

  // Bits needed to index n items. The result is never smaller than 1, so the
  // field stays legal when n is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W = idx_width(RF_NUM_REQ);

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. The search begins at the
//                requester after last_grant and wraps around.
//  Ports       : req_valid  in   request vector
//                last_grant in   index of the previous winner
//                winner     out  chosen index (holds last_grant when none)
//                any_valid  out  at least one request is present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int w_dist;
  int w_best;

  // Each requester's priority is its forward distance from last_grant+1.
  // The valid requester with the smallest distance wins.
  always_comb begin
    winner    = last_grant;
    any_valid = 1'b0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        winner    = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Lets NUM_REQ requesters share the single write port of the
//                register file. Grants are round-robin, and each grant opens a
//                locked write session. Every accepted beat is registered onto
//                the rf_* outputs one cycle after it is accepted.
//  Ports       : clk, rst (synchronous, active-high)
//                req_valid/req_ready/req_addr/req_data/req_last per requester
//                rf_write_en/rf_write_addr/rf_data_in to the register file
//                grant_id (current/last owner), busy (session open)
//  Config      : REGFILE_ARB_BURST_EN enables multi-beat sessions, which end
//                on req_last or after MAX_BURST beats. Without it every
//                session is exactly one beat.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ   = RF_NUM_REQ,
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          rf_write_en,
  output logic [ADDR_W-1:0]             rf_write_addr,
  output logic [DATA_W-1:0]             rf_data_in,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                          busy
);

  localparam int                   c_GRANT_W  = idx_width(NUM_REQ);
  localparam logic [c_GRANT_W-1:0] c_LAST_RST = c_GRANT_W'(NUM_REQ - 1);

  arb_state_t           r_state;
  logic [c_GRANT_W-1:0] r_owner;
  logic [c_GRANT_W-1:0] r_last_grant;
  logic                 r_rf_we;
  logic [ADDR_W-1:0]    r_rf_addr;
  logic [DATA_W-1:0]    r_rf_data;

  logic [c_GRANT_W-1:0] w_winner;
  logic                 w_any_valid;
  logic                 w_owner_valid;
  logic [ADDR_W-1:0]    w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]    w_data_arr [NUM_REQ];

`ifdef REGFILE_ARB_BURST_EN
  localparam int                 c_CNT_W    = idx_width(MAX_BURST);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);
  logic [c_CNT_W-1:0] r_burst_cnt;
`else
  // Single-beat sessions never look at req_last or MAX_BURST.
  localparam int c_UNUSED_MAX_BURST = MAX_BURST;
  logic w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  // Unpack the flat buses so the owner can select its lane directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_GRANT_W)
  ) u_rr_arbiter (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  assign w_owner_valid = req_valid[r_owner];

  // Ready depends only on state and owner, which prevents a valid->ready
  // combinational path.
  always_comb begin
    req_ready = '0;
    if (r_state == LOCKED) begin
      req_ready[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_grant <= c_LAST_RST;
      r_rf_we      <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_data    <= '0;
`ifdef REGFILE_ARB_BURST_EN
      r_burst_cnt  <= '0;
`endif
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
`ifdef REGFILE_ARB_BURST_EN
            r_burst_cnt  <= '0;
`endif
            r_state      <= LOCKED;
          end
        end
        LOCKED: begin
          if (!w_owner_valid) begin
            // An idle beat from the owner closes the session.
            r_state <= IDLE;
          end else begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= w_addr_arr[r_owner];
            r_rf_data <= w_data_arr[r_owner];
`ifdef REGFILE_ARB_BURST_EN
            r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
            if (req_last[r_owner] || (r_burst_cnt == c_CNT_LAST)) begin
              r_state <= IDLE;
            end
`else
            r_state <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_write_en   = r_rf_we;
  assign rf_write_addr = r_rf_addr;
  assign rf_data_in    = r_rf_data;
  assign grant_id      = r_owner;
  assign busy          = (r_state == LOCKED);

endmodule
`default_nettype wire
